// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: clears on start or reset, counts while enabled,
// flags when WIDTH iterations have elapsed.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] count;

    // Iteration count register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(WIDTH));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes) unit. One iteration per cycle, WIDTH iterations, one-cycle
// ready strobe; a new start in any state restarts with fresh operands.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t state, state_nxt;

    logic start;
    logic run;
    logic iter_done;
    logic step;
    logic finish;

    // Booth working state: {upper, multiplier, q_-1}
    logic signed [2*WIDTH:0]  prod_p0;
    logic signed [WIDTH-1:0]  mcand_p0;

    // Restoring-division working state on magnitudes
    logic [WIDTH-1:0] rem_p0;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] dvsr_p0;
    logic             qneg_p0;
    logic             dzero_p0;

    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;
    logic [WIDTH:0]   div_out;

    // Absolute value; the most negative value maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // One Booth step. The add is done one bit wider than the accumulator so
    // that the shifted-in sign is the true sign even when the W-bit sum would
    // overflow (multiplicand = most negative value).
    function automatic logic [2*WIDTH:0] booth_step(input logic [2*WIDTH:0] p,
                                                   input logic [WIDTH-1:0]  m);
        logic [WIDTH:0] acc;
        logic [WIDTH:0] mext;
        logic [WIDTH:0] sum;
        acc  = {p[2*WIDTH], p[2*WIDTH:WIDTH+1]};
        mext = {m[WIDTH-1], m};
        case (p[1:0])
            2'b01:   sum = acc + mext;
            2'b10:   sum = acc - mext;
            default: sum = acc;
        endcase
        return {sum[WIDTH], sum[WIDTH-1:0], p[WIDTH:1]};
    endfunction

    // One restoring-division step: returns {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic           qbit;
        sh   = {r, q[WIDTH-1]};
        qbit = 1'b0;
        if (sh >= {1'b0, d}) begin
            sh   = sh - {1'b0, d};
            qbit = 1'b1;
        end
        return {sh[WIDTH-1:0], q[WIDTH-2:0], qbit};
    endfunction

    // Apply quotient sign and flag divide-by-zero / positive overflow;
    // returns {exception, quotient}.
    function automatic logic [WIDTH:0] div_fix(input logic [WIDTH-1:0] qmag,
                                              input logic             neg,
                                              input logic             dz);
        if (dz) begin
            return {1'b1, {WIDTH{1'b0}}};
        end
        if (neg) begin
            return {1'b0, -qmag};
        end
        return {qmag[WIDTH-1], qmag};
    endfunction

    assign start  = ctrl_MULT | ctrl_DIV;
    assign run    = (state == MULT_RUN) || (state == DIV_RUN);
    assign step   = run & ~iter_done;
    assign finish = run & iter_done & ~start;

    multdiv_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk  (clock),
        .rst  (reset),
        .clr  (start),
        .en   (step),
        .done (iter_done)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and busy decode; a start pulse overrides any transition
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            MULT_RUN, DIV_RUN: begin
                busy = 1'b1;
                if (iter_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (ctrl_MULT) begin
            state_nxt = MULT_RUN;
        end else if (ctrl_DIV) begin
            state_nxt = DIV_RUN;
        end
    end

    // ---- stage p0: operand capture and per-cycle iteration ----
    // Load operands on start, otherwise advance the active datapath
    always_ff @(posedge clock) begin
        if (start) begin
            if (ctrl_MULT) begin
                prod_p0  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                mcand_p0 <= data_operandA;
            end else begin
                rem_p0   <= '0;
                quo_p0   <= magnitude(data_operandA);
                dvsr_p0  <= magnitude(data_operandB);
                qneg_p0  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dzero_p0 <= (data_operandB == '0);
            end
        end else if (step) begin
            if (state == MULT_RUN) begin
                prod_p0 <= booth_step(prod_p0, mcand_p0);
            end else begin
                {rem_p0, quo_p0} <= div_step(rem_p0, quo_p0, dvsr_p0);
            end
        end
    end

    assign mul_res = prod_p0[WIDTH:1];
    assign mul_ovf = !((&prod_p0[2*WIDTH:WIDTH]) || !(|prod_p0[2*WIDTH:WIDTH]));
    assign div_out = div_fix(quo_p0, qneg_p0, dzero_p0);

    // ---- output stage: result captured only on completion ----
    // Result/exception hold until the next completion; ready is a one-cycle strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            if (finish) begin
                if (state == MULT_RUN) begin
                    data_result    <= mul_res;
                    data_exception <= mul_ovf;
                end else begin
                    data_result    <= div_out[WIDTH-1:0];
                    data_exception <= div_out[WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed and random operations
// compared against an arithmetic reference model.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Reference: {exception, result} for signed multiply
    function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic [63:0] pv;
        logic ovf;
        p   = longint'($signed(x)) * longint'($signed(y));
        pv  = p;
        ovf = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000);
        return {ovf, pv[31:0]};
    endfunction

    // Reference: {exception, quotient} for signed truncating divide
    function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint q;
        logic [63:0] qv;
        if (y == 32'd0) return {1'b1, 32'd0};
        if (x == INT_MIN && y == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
        q  = longint'($signed(x)) / longint'($signed(y));
        qv = q;
        return {1'b0, qv[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a start pulse for one edge, then scramble the operands
    task automatic start_op(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        opa       = x;
        opb       = y;
        @(posedge clock);
        #1;
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        opa       = $urandom;
        opb       = $urandom;
    endtask

    // Count edges after the start edge until ready is seen (bounded)
    task automatic wait_rdy(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clock);
            #1;
            n++;
            if (data_resultRDY) break;
        end
    endtask

    task automatic finish_check(input string tag, input logic [32:0] e);
        int n;
        wait_rdy(n);
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_result"}, data_result, e[31:0]);
        check({tag, "_exc"}, 32'(data_exception), 32'(e[32]));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        logic [32:0] e;
        e = m ? ref_mul(x, y) : ref_div(x, y);
        start_op(m, d, x, y);
        finish_check(tag, e);
        @(posedge clock);
        #1;
        check({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] x;
        logic [31:0] y;
        logic [32:0] e;

        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        opa       = '0;
        opb       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", data_result, 32'd0);
        check("rst_exc", 32'(data_exception), 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed multiplies
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7xm3");
        check("mul_7xm3_value", data_result, 32'hFFFF_FFEB);
        do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        check("mul_ovf_flag", 32'(data_exception), 32'd1);
        do_op(1'b1, 1'b0, INT_MIN, 32'hFFFF_FFFF, "mul_min_m1");
        check("mul_min_m1_flag", 32'(data_exception), 32'd1);
        do_op(1'b1, 1'b0, INT_MIN, INT_MIN, "mul_min_min");

        // Directed divides
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_2_value", data_result, 32'hFFFF_FFFD);
        do_op(1'b0, 1'b1, 32'd100, 32'd7, "div_100_7");
        check("div_100_7_value", data_result, 32'd14);
        do_op(1'b0, 1'b1, 32'd5, 32'd0, "div_by0");
        check("div_by0_flag", 32'(data_exception), 32'd1);
        do_op(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF, "div_min_m1");
        check("div_min_m1_value", data_result, 32'h8000_0000);
        do_op(1'b0, 1'b1, INT_MIN, 32'd1, "div_min_1");
        do_op(1'b0, 1'b1, 32'd3, 32'hFFFF_FFF6, "div_small_neg");

        // Result holds while idle
        repeat (5) @(posedge clock);
        #1;
        check("hold_idle", data_result, 32'd0);

        // Abort a multiply with a divide four cycles later
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (4) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        finish_check("abort", {1'b0, 32'd5});

        // Both starts high: multiply wins
        do_op(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFB, "both_high");
        check("both_high_value", data_result, 32'hFFFF_FFD3);

        // Start during DONE: back-to-back operations
        start_op(1'b1, 1'b0, 32'd11, 32'd13);
        finish_check("b2b_first", ref_mul(32'd11, 32'd13));
        start_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd16);
        finish_check("b2b_second", ref_div(32'hFFFF_FF00, 32'd16));

        // Reset in the middle of an operation
        do_op(1'b1, 1'b0, 32'd3, 32'd4, "pre_reset");
        check("pre_reset_value", data_result, 32'd12);
        start_op(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_result", data_result, 32'd0);
        check("midrst_rdy", 32'(data_resultRDY), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        check("midrst_no_rdy", 32'(seen), 32'd0);
        do_op(1'b1, 1'b0, 32'd6, 32'd7, "post_reset");
        check("post_reset_value", data_result, 32'd42);

        // Random multiplies
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 2 == 1) y = $urandom_range(0, 65535);
            if (i % 4 == 3) y = -y;
            do_op(1'b1, 1'b0, x, y, "rand_mul");
        end

        // Random divides
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) y = $urandom_range(1, 20);
            if (i % 5 == 0) y = -y;
            if (i == 7) y = 32'd0;
            do_op(1'b0, 1'b1, x, y, "rand_div");
        end

        // Random abort: the second operation's result is the one delivered
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom_range(1, 1000);
            start_op(1'b0, 1'b1, $urandom, $urandom);
            repeat ($urandom_range(1, 25)) @(posedge clock);
            e = ref_mul(x, y);
            start_op(1'b1, 1'b0, x, y);
            finish_check("rand_abort", e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit that sits beside the combinational ALU (and32, or32, adder, shifters) in the execute stage.
- It accepts a one-cycle start pulse with two operands, runs for a fixed number of cycles, then returns a 32-bit result with an exception flag and a one-cycle ready strobe.
- The pipeline stalls the execute stage while the unit is busy.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_MULT  in  1  one-cycle start pulse for signed multiply.
- ctrl_DIV  in  1  one-cycle start pulse for signed divide.
- data_operandA  in  WIDTH  multiplicand or dividend; sampled only on the start edge.
- data_operandB  in  WIDTH  multiplier or divisor; sampled only on the start edge.
- data_result  out  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  out  1  overflow or divide-by-zero flag, valid with data_result.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  high while an operation is in flight (RUN states).

Behaviour:
- Reset
  - Sampled on the rising clock edge. Clears data_result, data_exception, data_resultRDY and busy to 0, and sets state to IDLE.
  - Reset mid-operation aborts the operation: no data_resultRDY is produced for it.
- States: IDLE, MULT_RUN, DIV_RUN, DONE.
  - IDLE: go to MULT_RUN on ctrl_MULT, or DIV_RUN on ctrl_DIV.
  - MULT_RUN / DIV_RUN: go to DONE when the iteration counter reaches WIDTH.
  - DONE: lasts exactly one cycle, then IDLE, unless a new start is sampled in that cycle.
- Start sampling
  - ctrl_MULT and ctrl_DIV are sampled in every state.
  - If both are high on the same edge, MULT wins.
  - A start sampled in a RUN state aborts the current operation and restarts with the new operands. The aborted operation never strobes RDY.
- Latency
  - If the start is sampled at edge k, data_resultRDY is high for exactly the cycle between edges k+WIDTH+1 and k+WIDTH+2 (33 edges for WIDTH=32).
  - busy is high from after edge k until after edge k+WIDTH+1.
- Multiply
  - Radix-2 Booth: one step per cycle over a 2*WIDTH+1-bit product register.
  - data_result = product[WIDTH-1:0].
  - data_exception = 1 if the product bits [2*WIDTH-1:WIDTH-1] are not all equal, i.e. the product does not fit in signed WIDTH bits.
- Divide
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign is A[msb] XOR B[msb]; truncation is toward zero; the remainder is discarded.
  - Divisor 0: data_result = 0, data_exception = 1, with the same latency as a normal divide.
  - A = 0x80000000 and B = 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- Output hold
  - data_result and data_exception update only on the edge that raises data_resultRDY.
  - They hold that value until the next completion or reset; an aborted operation leaves them unchanged.
- Start during DONE: RDY for the finishing operation is still asserted, and the new operation starts on that same edge.
- Operands changing after the start edge have no effect.

Decomposition:
- Shared package (multdiv_pkg):
  - WIDTH default.
  - State encoding: IDLE = 2'd0, MULT_RUN = 2'd1, DIV_RUN = 2'd2, DONE = 2'd3.
  - Constant INT_MIN = 32'h80000000.
- Sub-module multdiv_counter:
  - Counter of width clog2(WIDTH)+1 bits with synchronous clear on start or reset.
  - Enable input; terminal flag asserted when count == WIDTH.
- The Booth and restoring datapaths stay inline in multdiv_unit.

Test Plan:
- ctrl_MULT, A = 7, B = 0xFFFFFFFD → data_result = 0xFFFFFFEB, exception = 0; RDY high exactly at edge k+33 and low at k+34.
- ctrl_MULT, A = 0x00010000, B = 0x00010000 → data_result = 0x00000000, exception = 1. Separately, A = 0x80000000, B = 0xFFFFFFFF → exception = 1.
- ctrl_DIV, A = 0xFFFFFFF9, B = 2 → data_result = 0xFFFFFFFD, exception = 0. Separately, A = 100, B = 7 → 14.
- ctrl_DIV, A = 5, B = 0 → data_result = 0, exception = 1 at edge k+33. Separately, A = 0x80000000, B = 0xFFFFFFFF → 0x80000000, exception = 1.
- Abort and restart:
  - ctrl_MULT (3×4), then at k+5 ctrl_DIV (20/4).
  - Exactly one RDY, at edge (k+5)+33, with result 5; no RDY at k+33.
  - ctrl_MULT and ctrl_DIV both high → multiply performed.
- Reset mid-operation:
  - After a completed result of 12, start 6×7 and assert reset at edge k+10.
  - data_result is cleared to 0 and RDY never asserts.
  - The next ctrl_MULT 6×7 completes normally with 42 after 33 edges.
